// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, MD timer state type and hazard helper
package cpu_pkg;

  localparam logic [1:0] T_NONE = 2'd3;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A producer stalls a consumer only when its result is not ready before the consumer needs it.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    logic hit;
    hit = ((src == e_a3) && (e_tnew > tuse)) ||
          ((src == m_a3) && (m_tnew > tuse));
    return (src != 5'd0) && (tuse != T_NONE) && hit;
  endfunction

endpackage

// File: rtl/md_timer.sv
// rtl/md_timer.sv - multiply/divide busy timer: IDLE/BUSY state plus down-counter
module md_timer
  import cpu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while already BUSY is dropped; the D-stage hazard keeps it from happening.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = div_i ? DIV_LOAD : MULT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - operand and MD hazard detection, PC/F-D hold, D/E bubble, stall counter
module stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_Tuse,
  input  logic [1:0]  D_rt_Tuse,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stop,
  output logic        E_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        hz_rs, hz_rt, hz_md, hz_any;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start_i (E_md_start),
    .div_i   (E_md_div),
    .busy_o  (md_busy)
  );

  assign hz_rs  = reg_hazard(D_rs, D_rs_Tuse, E_A3, E_Tnew, M_A3, M_Tnew);
  assign hz_rt  = reg_hazard(D_rt, D_rt_Tuse, E_A3, E_Tnew, M_A3, M_Tnew);
  assign hz_md  = D_is_md && (E_md_start || md_busy);
  assign hz_any = hz_rs || hz_rt || hz_md;

  // Gated by reset so the PC is never held while the core is in reset.
  assign stop    = reset && hz_any;
  assign E_flush = stop;

  assign stall_cnt_d = (stop && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - scoreboard bench for stall_ctrl hazard, MD timer and stall counter
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_rs_Tuse, D_rt_Tuse, E_Tnew, M_Tnew;
  logic        D_is_md, E_md_start, E_md_div;
  logic        stop, E_flush, md_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    string       tag;
    logic        stop;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_cnt;
  int          n_checks;
  int          n_errors;

  stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_Tuse  (D_rs_Tuse),
    .D_rt_Tuse  (D_rt_Tuse),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .D_is_md    (D_is_md),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stop       (stop),
    .E_flush    (E_flush),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_Tuse = 2'd3; D_rt_Tuse = 2'd3;
    E_A3 = 5'd0; M_A3 = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
    D_is_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  task automatic load_use();
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_Tuse = 2'd1;
  endtask

  // Inputs are set just after a rising edge; the expectation for this cycle is queued
  // and checked by the monitor at the falling edge.
  task automatic step(input string tag, input logic e_stop, input logic e_busy);
    exp_t e;
    e.tag = tag; e.stop = e_stop; e.busy = e_busy; e.cnt = exp_cnt;
    sb.push_back(e);
    if (e_stop && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_stop"},    32'(stop),    32'(e.stop));
      check({e.tag, "_flush"},   32'(E_flush), 32'(e.stop));
      check({e.tag, "_busy"},    32'(md_busy), 32'(e.busy));
      check({e.tag, "_cnt"},     stall_cnt,    e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; exp_cnt = 32'd0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    load_use();
    D_is_md = 1'b1;
    #1;
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    idle_inputs();
    reset = 1'b1;

    // load-use, then the producer has moved to M with its result ready
    load_use();
    step("lu_hit", 1'b1, 1'b0);
    idle_inputs();
    D_rs = 5'd8; D_rs_Tuse = 2'd1; M_A3 = 5'd8; M_Tnew = 2'd1;
    step("lu_clear", 1'b0, 1'b0);
    idle_inputs();
    D_rt = 5'd9; D_rt_Tuse = 2'd0; M_A3 = 5'd9; M_Tnew = 2'd1;
    step("rt_m_hit", 1'b1, 1'b0);
    idle_inputs();
    D_rs = 5'd8; D_rs_Tuse = 2'd3; E_A3 = 5'd8; E_Tnew = 2'd2;
    step("tuse_none", 1'b0, 1'b0);
    idle_inputs();
    D_rs = 5'd0; D_rs_Tuse = 2'd0; E_A3 = 5'd0; E_Tnew = 2'd2;
    step("zero_reg", 1'b0, 1'b0);

    // mult followed by an MD instruction in D; one cycle also carries a register hazard
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
    step("mult_start", 1'b1, 1'b0);
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) load_use();
      else begin E_A3 = 5'd0; E_Tnew = 2'd0; D_rs = 5'd0; D_rs_Tuse = 2'd3; end
      step("mult_busy", 1'b1, 1'b1);
    end
    E_A3 = 5'd0; E_Tnew = 2'd0; D_rs = 5'd0; D_rs_Tuse = 2'd3;
    step("mult_done", 1'b0, 1'b0);

    // div with no MD consumer; a stray start mid-busy must not reload
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1;
    step("div_start", 1'b0, 1'b0);
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int i = 0; i < 10; i++) begin
      E_md_start = (i == 3);
      step("div_busy", 1'b0, 1'b1);
    end
    E_md_start = 1'b0;
    step("div_done", 1'b0, 1'b0);

    // reset pulled three cycles into a div
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1;
    step("rdiv_start", 1'b0, 1'b0);
    idle_inputs();
    for (int i = 0; i < 3; i++) step("rdiv_busy", 1'b0, 1'b1);
    D_is_md = 1'b1;
    reset = 1'b0;
    #1;
    check("rdiv_async_busy", 32'(md_busy), 32'd0);
    check("rdiv_async_cnt", stall_cnt, 32'd0);
    check("rdiv_async_stop", 32'(stop), 32'd0);
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step("post_rst", 1'b0, 1'b0);
    idle_inputs();
    step("post_rst_idle", 1'b0, 1'b0);

    // saturation from a forced preload
    force dut.stall_cnt_d = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.stall_cnt_d;
    exp_cnt = 32'hFFFF_FFFE;
    check("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    load_use();
    for (int i = 0; i < 3; i++) step("sat", 1'b1, 1'b0);
    idle_inputs();
    step("sat_hold", 1'b0, 1'b0);

    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
